// File: rtl/serial_tx_path.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx_path
// Description : Buffered 8N1 UART transmitter with runtime bit divisor, byte
//               FIFO with sticky overflow, and optional CTS gating enabled by
//               defining CTS_FLOWCTRL_EN.
// Revision    : 1.0
// ============================================================================
module serial_tx_path #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIV_WIDTH-1:0]  divisor,
   input  logic                  wrEn,
   input  logic [7:0]            wrData,
   output logic                  wrFull,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow,
   input  logic                  clrOvf,
   input  logic                  ctsIn,
   output logic                  tx,
   output logic                  txActive
);
   localparam int unsigned c_DEPTH = 1 << DEPTH_LOG2;
   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   logic [7:0]            r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wrPtr, r_rdPtr;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_ovf;
   logic [1:0]            r_state, w_stateNext;
   logic [DIV_WIDTH-1:0]  r_timer, r_div, w_divEff;
   logic [2:0]            r_bitCnt;
   logic [7:0]            r_shift;
   logic                  w_full, w_empty, w_bitEnd, w_popSlot, w_pop, w_push, w_gate;
   logic                  w_tx, w_active;

`ifdef CTS_FLOWCTRL_EN
   logic r_ctsMeta, r_ctsSync;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctsMeta <= 1'b0;
         r_ctsSync <= 1'b0;
      end else begin
         r_ctsMeta <= ctsIn;
         r_ctsSync <= r_ctsMeta;
      end
   end
   assign w_gate = r_ctsSync;
`else
   logic w_unusedCts;
   assign w_unusedCts = ctsIn;
   assign w_gate      = 1'b1;
`endif

   // level never exceeds the depth, so its MSB alone marks full
   assign w_full    = r_level[DEPTH_LOG2];
   assign w_empty   = (r_level == '0);
   assign w_bitEnd  = (r_timer == '0);
   assign w_popSlot = (r_state == c_IDLE) || ((r_state == c_STOP) && w_bitEnd);
   assign w_pop     = w_popSlot && !w_empty && w_gate;
   assign w_push    = wrEn && (!w_full || w_pop);
   assign w_divEff  = (divisor < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : divisor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + DEPTH_LOG2'(1);
         if (w_pop)  r_rdPtr <= r_rdPtr + DEPTH_LOG2'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
            2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
            default: r_level <= r_level;
         endcase
         if (wrEn && !w_push) r_ovf <= 1'b1;
         else if (clrOvf)     r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wrPtr] <= wrData;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         c_IDLE:  if (w_pop) w_stateNext = c_START;
         c_START: if (w_bitEnd) w_stateNext = c_DATA;
         c_DATA:  if (w_bitEnd && (r_bitCnt == 3'd7)) w_stateNext = c_STOP;
         c_STOP:  if (w_bitEnd) w_stateNext = w_pop ? c_START : c_IDLE;
         default: w_stateNext = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer  <= '0;
         r_div    <= DIV_WIDTH'(2);
         r_bitCnt <= '0;
         r_shift  <= '0;
      end else if (w_pop) begin
         r_div    <= w_divEff;
         r_timer  <= w_divEff - DIV_WIDTH'(1);
         r_shift  <= r_mem[r_rdPtr];
         r_bitCnt <= '0;
      end else if (r_state != c_IDLE) begin
         if (w_bitEnd) begin
            r_timer <= r_div - DIV_WIDTH'(1);
            if (r_state == c_DATA) begin
               r_shift  <= r_shift >> 1;
               r_bitCnt <= r_bitCnt + 3'd1;
            end
         end else begin
            r_timer <= r_timer - DIV_WIDTH'(1);
         end
      end
   end

   // decoded straight from state so reset forces the line idle asynchronously
   always_comb begin
      w_tx     = 1'b1;
      w_active = 1'b0;
      case (r_state)
         c_START: begin w_tx = 1'b0;       w_active = 1'b1; end
         c_DATA:  begin w_tx = r_shift[0]; w_active = 1'b1; end
         c_STOP:  begin w_tx = 1'b1;       w_active = 1'b1; end
         default: begin w_tx = 1'b1;       w_active = 1'b0; end
      endcase
   end

   assign tx       = w_tx;
   assign txActive = w_active;
   assign wrFull   = w_full;
   assign level    = r_level;
   assign overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_serial_tx_path.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx_path
// Description : Scoreboard bench for serial_tx_path; a line monitor decodes
//               every frame and checks it against queued expected bytes.
// Revision    : 1.0
// ============================================================================
module tb_serial_tx_path;
   localparam int DL = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] divisor = 16'd4;
   logic          wrEn = 1'b0;
   logic [7:0]    wrData = 8'h00;
   logic          clrOvf = 1'b0;
   logic          ctsIn = 1'b1;
   logic          wrFull, overflow, tx, txActive;
   logic [DL:0]   level;

   typedef struct {
      logic [7:0] b;
      int         d;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int errors = 0;

   serial_tx_path #(.DEPTH_LOG2(DL), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .divisor(divisor), .wrEn(wrEn), .wrData(wrData),
      .wrFull(wrFull), .level(level), .overflow(overflow), .clrOvf(clrOvf),
      .ctsIn(ctsIn), .tx(tx), .txActive(txActive)
   );

   always #5 clk = ~clk;

   function automatic int eff_div(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, req);
      end
   endtask

   // one clock edge; called and returns at a falling edge
   task automatic step(input bit we, input logic [7:0] d, input bit clr);
      wrEn   = we;
      wrData = d;
      clrOvf = clr;
      @(negedge clk);
      wrEn   = 1'b0;
      clrOvf = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      exp_t e;
      e.b = b;
      e.d = eff_div(int'(divisor));
      exp_q.push_back(e);
      step(1'b1, b, 1'b0);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((exp_q.size() != 0 || txActive) && n < max) begin
         step(1'b0, 8'h00, 1'b0);
         n++;
      end
      checks++;
      if (n >= max) begin
         errors++;
         $display("FAIL drain_timeout got %0d pending expected 0 after %0d cycles", exp_q.size(), max);
      end
   endtask

   // line monitor: every cycle of every frame is compared to the ideal 8N1 waveform
   initial begin : monitor
      bit prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 1'b1;
         end else if (prev && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame got start bit expected idle line");
               prev = tx;
            end else begin
               exp_t e;
               int bad = 0;
               bit aborted = 1'b0;
               logic [7:0] got = 8'h00;
               e = exp_q.pop_front();
               for (int c = 0; c < 10 * e.d; c++) begin
                  int bi;
                  logic expv;
                  if (c > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  bi   = c / e.d;
                  expv = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : e.b[bi-1];
                  if (tx !== expv || txActive !== 1'b1) bad++;
                  if (bi >= 1 && bi <= 8 && (c % e.d) == e.d / 2) got[bi-1] = tx;
               end
               if (!aborted) begin
                  checks++;
                  if (bad != 0 || got !== e.b) begin
                     errors++;
                     $display("FAIL frame got %02h expected %02h div %0d bad_cycles %0d", got, e.b, e.d, bad);
                  end
               end
               prev = aborted ? 1'b1 : tx;
            end
         end else begin
            prev = tx;
         end
      end
   end

   initial begin : stim
      logic [7:0] ob [19];
      int bad;
      @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_txActive", txActive, 0);
      chk("reset_wrFull", wrFull, 0);
      chk("reset_level", level, 0);
      chk("reset_overflow", overflow, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) step(1'b0, 8'h00, 1'b0);

      // single byte, div 4: pop one edge after the write, 40-cycle frame
      divisor = 16'd4;
      send(8'hA5);
      chk("lat_level_after_write", level, 1);
      step(1'b0, 8'h00, 1'b0);
      chk("lat_level_after_pop", level, 0);
      chk("lat_tx_start", tx, 0);
      chk("lat_txActive_start", txActive, 1);
      repeat (39) step(1'b0, 8'h00, 1'b0);
      chk("single_txActive_e40", txActive, 1);
      step(1'b0, 8'h00, 1'b0);
      chk("single_txActive_e41", txActive, 0);
      drain(200);

      // back-to-back at div 2: contiguous frames, level drops at each start
      divisor = 16'd2;
      send(8'h00);
      send(8'hFF);
      send(8'h55);
      chk("b2b_level_e2", level, 2);
      repeat (18) step(1'b0, 8'h00, 1'b0);
      chk("b2b_level_e20", level, 2);
      step(1'b0, 8'h00, 1'b0);
      chk("b2b_level_e21", level, 1);
      chk("b2b_tx_e21", tx, 0);
      repeat (20) step(1'b0, 8'h00, 1'b0);
      chk("b2b_level_e41", level, 0);
      chk("b2b_tx_e41", tx, 0);
      drain(200);

      // fill to full at div 2, write exactly at the pop edge, then a dropped write
      for (int i = 0; i < 19; i++) ob[i] = 8'($urandom);
      for (int i = 0; i < 17; i++) send(ob[i]);
      chk("full_level", level, 16);
      chk("full_wrFull", wrFull, 1);
      chk("full_overflow", overflow, 0);
      repeat (4) step(1'b0, 8'h00, 1'b0);
      send(ob[17]);
      chk("popwrite_level", level, 16);
      chk("popwrite_overflow", overflow, 0);
      step(1'b1, ob[18], 1'b1);
      chk("drop_set_wins", overflow, 1);
      chk("drop_level", level, 16);
      step(1'b0, 8'h00, 1'b1);
      chk("clr_overflow", overflow, 0);
      drain(1000);

      // divisor change mid-frame affects only the next frame
      divisor = 16'd8;
      send(8'h3C);
      repeat (25) step(1'b0, 8'h00, 1'b0);
      divisor = 16'd3;
      send(8'h5A);
      drain(400);
      divisor = 16'd0;
      send(8'h96);
      drain(200);
      divisor = 16'd1;
      send(8'h0F);
      drain(200);

      // randomized bursts; the burst length keeps the FIFO below full
      for (int k = 0; k < 8; k++) begin
         int n;
         divisor = 16'($urandom_range(0, 6));
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) begin
            send(8'($urandom));
            repeat ($urandom_range(0, 2)) step(1'b0, 8'h00, 1'b0);
         end
         drain(n * 60 + 200);
      end

      // asynchronous reset in the middle of a data bit
      divisor = 16'd4;
      send(8'hC3);
      send(8'h81);
      repeat (10) step(1'b0, 8'h00, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("rst_tx", tx, 1);
      chk("rst_txActive", txActive, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         step(1'b0, 8'h00, 1'b0);
         if (tx !== 1'b1 || txActive !== 1'b0) bad++;
      end
      chk("post_reset_idle_cycles", bad, 0);
      chk("post_reset_level", level, 0);
      send(8'h7E);
      drain(200);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
